// File: rtl/perf_monitor_if.sv
// perf_monitor_if: event inputs, clear and read port of the performance monitor.
// master drives events/requests (the pipeline side); slave is the monitor.
interface perf_monitor_if #(
    parameter int unsigned CNT_W = 32
);
    logic             reg_write;
    logic             mem_write;
    logic             halt;
    logic             icache_req;
    logic             icache_hit;
    logic             dcache_req;
    logic             dcache_hit;
    logic             clr;
    logic             rd_req;
    logic [2:0]       rd_sel;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;
    logic [5:0]       ovf;
    logic             halted;

    modport master (
        output reg_write, mem_write, halt, icache_req, icache_hit, dcache_req, dcache_hit,
        output clr, rd_req, rd_sel,
        input  rd_valid, rd_data, ovf, halted
    );

    modport slave (
        input  reg_write, mem_write, halt, icache_req, icache_hit, dcache_req, dcache_hit,
        input  clr, rd_req, rd_sel,
        output rd_valid, rd_data, ovf, halted
    );
endinterface

// File: rtl/perf_monitor.sv
// perf_monitor: saturating cycle/retire/cache event counters, frozen on halt, registered read port.
// Define PERF_CACHE_EN to build the cache counters (rd_sel 2..5); otherwise they read as 0.
module perf_monitor #(
    parameter int unsigned CNT_W = 32
) (
    input logic           clk,
    input logic           rst_n,
    perf_monitor_if.slave bus
);

`ifdef PERF_CACHE_EN
    localparam int unsigned NumCnt = 6;
`else
    localparam int unsigned NumCnt = 2;
`endif

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e             stateQ, stateD;
    logic               countEn;
    logic [NumCnt-1:0]  evt;
    logic [CNT_W-1:0]   cntQ [NumCnt];
    logic [NumCnt-1:0]  ovfQ;
    logic [CNT_W-1:0]   rdMux;
    logic               rdValidQ;
    logic [CNT_W-1:0]   rdDataQ;

    // clr wins over halt and always returns to RUN
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StRun:    if (bus.halt) stateD = StHalted;
            StHalted: stateD = StHalted;
            default:  stateD = StRun;
        endcase
        if (bus.clr) stateD = StRun;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StRun;
        end else begin
            stateQ <= stateD;
        end
    end

    assign countEn = (stateQ == StRun) && !bus.clr;

    always_comb begin
        evt    = '0;
        evt[0] = 1'b1;
        evt[1] = bus.halt | bus.reg_write | bus.mem_write;
`ifdef PERF_CACHE_EN
        evt[2] = bus.icache_req;
        evt[3] = bus.icache_hit & bus.icache_req;
        evt[4] = bus.dcache_req;
        evt[5] = bus.dcache_hit & bus.dcache_req;
`endif
    end

`ifndef PERF_CACHE_EN
    logic unusedCache;
    assign unusedCache = ^{bus.icache_req, bus.icache_hit, bus.dcache_req, bus.dcache_hit};
`endif

    // Saturate at all-ones: hold the value and latch the sticky flag instead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumCnt; i++) cntQ[i] <= '0;
            ovfQ <= '0;
        end else if (bus.clr) begin
            for (int i = 0; i < NumCnt; i++) cntQ[i] <= '0;
            ovfQ <= '0;
        end else if (countEn) begin
            for (int i = 0; i < NumCnt; i++) begin
                if (evt[i]) begin
                    if (&cntQ[i]) ovfQ[i] <= 1'b1;
                    else          cntQ[i] <= cntQ[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        rdMux = '0;
        for (int i = 0; i < NumCnt; i++) begin
            if (bus.rd_sel == 3'(i)) rdMux = cntQ[i];
        end
    end

    // Samples the pre-update counter, so a read in the clr cycle returns the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdValidQ <= 1'b0;
            rdDataQ  <= '0;
        end else begin
            rdValidQ <= bus.rd_req;
            if (bus.rd_req) rdDataQ <= rdMux;
        end
    end

    assign bus.rd_valid = rdValidQ;
    assign bus.rd_data  = rdDataQ;
    assign bus.ovf      = 6'(ovfQ);
    assign bus.halted   = (stateQ == StHalted);

endmodule
